// File: rtl/tachyon_fetch_arb_pkg.sv
// tachyon_mem_pkg: shared index-width helper and grant one-hot type for the Tachyon memory arbiters
package tachyon_mem_pkg;

    localparam int MAX_CORES = 16;

    typedef struct packed {
        logic                 dbg;
        logic [MAX_CORES-1:0] core;
    } grant_t;

    function automatic int CORE_IDX_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tachyon_fetch_arb_if.sv
// tachyon_fetch_arb_if: core fetch, debug and RAM signals of the fetch arbiter
interface tachyon_fetch_arb_if #(
    parameter int NR_CORES   = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [NR_CORES-1:0]            core_req;
    logic [NR_CORES*ADDR_WIDTH-1:0] core_addr;
    logic [NR_CORES-1:0]            core_gnt;
    logic [NR_CORES-1:0]            core_rvalid;
    logic [DATA_WIDTH-1:0]          core_rdata;
    logic                           dbg_req;
    logic                           dbg_wr;
    logic [ADDR_WIDTH-1:0]          dbg_addr;
    logic [DATA_WIDTH-1:0]          dbg_wdata;
    logic                           dbg_gnt;
    logic                           dbg_rvalid;
    logic [DATA_WIDTH-1:0]          dbg_rdata;
    logic                           ram_rd_en;
    logic [ADDR_WIDTH-1:0]          ram_rd_addr;
    logic [DATA_WIDTH-1:0]          ram_rd_data;
    logic                           ram_wr_en;
    logic [ADDR_WIDTH-1:0]          ram_wr_addr;
    logic [DATA_WIDTH-1:0]          ram_wr_data;

    // Cores, debug port and RAM side
    modport master (
        output core_req, core_addr, dbg_req, dbg_wr, dbg_addr, dbg_wdata, ram_rd_data,
        input  core_gnt, core_rvalid, core_rdata, dbg_gnt, dbg_rvalid, dbg_rdata,
        input  ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data
    );

    // Arbiter side
    modport slave (
        input  core_req, core_addr, dbg_req, dbg_wr, dbg_addr, dbg_wdata, ram_rd_data,
        output core_gnt, core_rvalid, core_rdata, dbg_gnt, dbg_rvalid, dbg_rdata,
        output ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data
    );

endinterface

// File: rtl/tachyon_fetch_arb_rr_pick.sv
// tachyon_rr_pick: combinational round-robin picker, first requester after last_i wins
module tachyon_rr_pick
    import tachyon_mem_pkg::*;
#(
    parameter int N = 2,
    parameter int W = CORE_IDX_W(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] last_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o
);

    logic [W-1:0] c;

    // Scan from farthest to nearest so the closest requester after last_i overwrites the rest
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        c     = '0;
        for (int k = N; k >= 1; k--) begin
            c = W'((int'(last_i) + k) % N);
            if (req_i[c]) begin
                gnt_o = N'(1) << c;
                idx_o = c;
            end
        end
    end

endmodule

// File: rtl/tachyon_fetch_arb.sv
// tachyon_fetch_arb: round-robin core fetch arbiter with bounded-priority debug channel onto SimRAM
module tachyon_fetch_arb
    import tachyon_mem_pkg::*;
#(
    parameter int NR_CORES   = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DBG_BURST  = 4
) (
    input  logic           clk,
    input  logic           rst,
    tachyon_fetch_arb_if.slave bus
);

    localparam int IW = CORE_IDX_W(NR_CORES);
    localparam int BW = $clog2(DBG_BURST + 1);

    logic [IW-1:0]       last_q, last_d, pick_idx;
    logic [NR_CORES-1:0] pick_gnt;
    logic [BW-1:0]       burst_q, burst_d;
    grant_t              rsp_q, rsp_d;
    logic                any_core, dbg_win, core_win;

    tachyon_rr_pick #(.N(NR_CORES), .W(IW)) u_pick (
        .req_i  (bus.core_req),
        .last_i (last_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx)
    );

    // Grant selection, RAM steering and next-state; reset masks grants and pending read returns
    always_comb begin
        any_core         = |bus.core_req;
        dbg_win          = ~rst & bus.dbg_req & (~any_core | (burst_q < BW'(DBG_BURST)));
        core_win         = ~rst & any_core & ~dbg_win;
        bus.core_gnt     = core_win ? pick_gnt : '0;
        bus.dbg_gnt      = dbg_win;
        bus.ram_rd_en    = core_win | (dbg_win & ~bus.dbg_wr);
        bus.ram_rd_addr  = core_win ? bus.core_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH]
                         : bus.ram_rd_en ? bus.dbg_addr : '0;
        bus.ram_wr_en    = dbg_win & bus.dbg_wr;
        bus.ram_wr_addr  = bus.ram_wr_en ? bus.dbg_addr : '0;
        bus.ram_wr_data  = bus.ram_wr_en ? bus.dbg_wdata : '0;
        bus.core_rvalid  = rst ? '0 : rsp_q.core[NR_CORES-1:0];
        bus.dbg_rvalid   = ~rst & rsp_q.dbg;
        bus.core_rdata   = bus.ram_rd_data;
        bus.dbg_rdata    = bus.ram_rd_data;
        last_d           = core_win ? pick_idx : last_q;
        burst_d          = (core_win | ~any_core) ? '0
                         : (dbg_win && burst_q < BW'(DBG_BURST)) ? burst_q + BW'(1) : burst_q;
        rsp_d.dbg        = dbg_win & ~bus.dbg_wr;
        rsp_d.core       = MAX_CORES'(bus.core_gnt);
    end

    // Arbitration state; last_core resets to the top index so core 0 goes first
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q  <= IW'(NR_CORES - 1);
            burst_q <= '0;
            rsp_q   <= '0;
        end else begin
            last_q  <= last_d;
            burst_q <= burst_d;
            rsp_q   <= rsp_d;
        end
    end

endmodule

// File: tb/tb_tachyon_fetch_arb.sv
// tb_tachyon_fetch_arb: table-driven directed checks of tachyon_fetch_arb with a behavioural SimRAM
module tb_tachyon_fetch_arb;

    localparam int NC = 4;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam logic [31:0] A1 = 32'h1111_0010;
    localparam logic [31:0] A2 = 32'h2222_0020;
    localparam logic [31:0] A3 = 32'h3333_0030;
    localparam logic [31:0] A4 = 32'h4444_0040;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;

    typedef struct {
        logic          rst;
        logic [NC-1:0] creq;
        logic          dreq;
        logic          dwr;
        logic [AW-1:0] daddr;
        logic [DW-1:0] dwd;
        logic [NC-1:0] egnt;
        logic          edg;
        logic          erd;
        logic          ewr;
        logic [AW-1:0] eaddr;
        logic [NC-1:0] ecrv;
        logic          edrv;
        logic [DW-1:0] edata;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int tests = 0;
    int fails = 0;
    logic [DW-1:0] mem [256];
    vec_t v [$];

    tachyon_fetch_arb_if #(.NR_CORES(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    tachyon_fetch_arb #(.NR_CORES(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DBG_BURST(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
        if (bus.ram_rd_en) bus.ram_rd_data <= mem[bus.ram_rd_addr];
    end

    function automatic vec_t mk(input logic r, input logic [NC-1:0] cq, input logic dq, input logic dw,
                                input logic [AW-1:0] da, input logic [DW-1:0] wd,
                                input logic [NC-1:0] eg, input logic edg_, input logic erd_, input logic ewr_,
                                input logic [AW-1:0] ea, input logic [NC-1:0] ecv, input logic edv,
                                input logic [DW-1:0] ed);
        vec_t t;
        t.rst = r; t.creq = cq; t.dreq = dq; t.dwr = dw; t.daddr = da; t.dwd = wd;
        t.egnt = eg; t.edg = edg_; t.erd = erd_; t.ewr = ewr_; t.eaddr = ea;
        t.ecrv = ecv; t.edrv = edv; t.edata = ed;
        return t;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL row %0d %s: got %h, expected %h", row, nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        rst         = t.rst;
        bus.core_req = t.creq;
        bus.dbg_req = t.dreq;
        bus.dbg_wr  = t.dwr;
        bus.dbg_addr = t.daddr;
        bus.dbg_wdata = t.dwd;
    endtask

    initial begin
        int lat;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = A1; mem[8'h20] = A2; mem[8'h30] = A3; mem[8'h40] = A4;
        bus.core_addr = {8'h40, 8'h30, 8'h20, 8'h10};
        bus.ram_rd_data = '0;
        //         rst creq    dq  dw  daddr  wdata  egnt    dg  rd  wr  eaddr  ecrv    drv rdata
        v.push_back(mk(1, 4'hF, 1, 0, 8'h40, 0,  4'h0, 0, 0, 0, 8'h00, 4'h0, 0, 0));
        v.push_back(mk(1, 4'hF, 1, 0, 8'h40, 0,  4'h0, 0, 0, 0, 8'h00, 4'h0, 0, 0));
        v.push_back(mk(0, 4'h3, 0, 0, 8'h00, 0,  4'h1, 0, 1, 0, 8'h10, 4'h0, 0, 0));
        v.push_back(mk(0, 4'hF, 0, 0, 8'h00, 0,  4'h2, 0, 1, 0, 8'h20, 4'h1, 0, A1));
        v.push_back(mk(0, 4'hF, 0, 0, 8'h00, 0,  4'h4, 0, 1, 0, 8'h30, 4'h2, 0, A2));
        v.push_back(mk(0, 4'hF, 0, 0, 8'h00, 0,  4'h8, 0, 1, 0, 8'h40, 4'h4, 0, A3));
        v.push_back(mk(0, 4'hF, 0, 0, 8'h00, 0,  4'h1, 0, 1, 0, 8'h10, 4'h8, 0, A4));
        v.push_back(mk(0, 4'h0, 0, 0, 8'h00, 0,  4'h0, 0, 0, 0, 8'h00, 4'h1, 0, A1));
        v.push_back(mk(0, 4'h2, 1, 0, 8'h40, 0,  4'h0, 1, 1, 0, 8'h40, 4'h0, 0, 0));
        v.push_back(mk(0, 4'h2, 1, 0, 8'h40, 0,  4'h0, 1, 1, 0, 8'h40, 4'h0, 1, A4));
        v.push_back(mk(0, 4'h2, 1, 0, 8'h40, 0,  4'h0, 1, 1, 0, 8'h40, 4'h0, 1, A4));
        v.push_back(mk(0, 4'h2, 1, 0, 8'h40, 0,  4'h0, 1, 1, 0, 8'h40, 4'h0, 1, A4));
        v.push_back(mk(0, 4'h2, 1, 0, 8'h40, 0,  4'h2, 0, 1, 0, 8'h20, 4'h0, 1, A4));
        v.push_back(mk(0, 4'h2, 1, 0, 8'h40, 0,  4'h0, 1, 1, 0, 8'h40, 4'h2, 0, A2));
        v.push_back(mk(0, 4'h0, 1, 1, 8'h08, DB, 4'h0, 1, 0, 1, 8'h08, 4'h0, 1, A4));
        v.push_back(mk(0, 4'h0, 1, 0, 8'h08, 0,  4'h0, 1, 1, 0, 8'h08, 4'h0, 0, 0));
        v.push_back(mk(0, 4'h0, 0, 0, 8'h00, 0,  4'h0, 0, 0, 0, 8'h00, 4'h0, 1, DB));
        v.push_back(mk(0, 4'h4, 0, 0, 8'h00, 0,  4'h4, 0, 1, 0, 8'h30, 4'h0, 0, 0));
        v.push_back(mk(0, 4'h4, 0, 0, 8'h00, 0,  4'h4, 0, 1, 0, 8'h30, 4'h4, 0, A3));
        v.push_back(mk(0, 4'h4, 0, 0, 8'h00, 0,  4'h4, 0, 1, 0, 8'h30, 4'h4, 0, A3));
        v.push_back(mk(0, 4'h0, 0, 0, 8'h00, 0,  4'h0, 0, 0, 0, 8'h00, 4'h4, 0, A3));
        v.push_back(mk(0, 4'h1, 0, 0, 8'h00, 0,  4'h1, 0, 1, 0, 8'h10, 4'h0, 0, 0));
        v.push_back(mk(1, 4'hF, 1, 0, 8'h40, 0,  4'h0, 0, 0, 0, 8'h00, 4'h0, 0, 0));
        v.push_back(mk(0, 4'h0, 0, 0, 8'h00, 0,  4'h0, 0, 0, 0, 8'h00, 4'h0, 0, 0));
        v.push_back(mk(0, 4'h3, 0, 0, 8'h00, 0,  4'h1, 0, 1, 0, 8'h10, 4'h0, 0, 0));
        @(posedge clk);
        #1;
        foreach (v[i]) begin
            drive(v[i]);
            #4;
            chk("core_gnt", i, 32'(bus.core_gnt), 32'(v[i].egnt));
            chk("dbg_gnt", i, 32'(bus.dbg_gnt), 32'(v[i].edg));
            chk("ram_rd_en", i, 32'(bus.ram_rd_en), 32'(v[i].erd));
            chk("ram_wr_en", i, 32'(bus.ram_wr_en), 32'(v[i].ewr));
            if (v[i].erd) chk("ram_rd_addr", i, 32'(bus.ram_rd_addr), 32'(v[i].eaddr));
            if (v[i].ewr) chk("ram_wr_addr", i, 32'(bus.ram_wr_addr), 32'(v[i].eaddr));
            if (v[i].ewr) chk("ram_wr_data", i, bus.ram_wr_data, v[i].dwd);
            chk("core_rvalid", i, 32'(bus.core_rvalid), 32'(v[i].ecrv));
            chk("dbg_rvalid", i, 32'(bus.dbg_rvalid), 32'(v[i].edrv));
            if (v[i].ecrv != 0) chk("core_rdata", i, bus.core_rdata, v[i].edata);
            if (v[i].edrv) chk("dbg_rdata", i, bus.dbg_rdata, v[i].edata);
            @(posedge clk);
            #1;
        end
        // Standalone debug read: bounded wait for the return, which must come exactly one cycle later
        rst = 1'b0; bus.core_req = '0; bus.dbg_req = 1'b1; bus.dbg_wr = 1'b0; bus.dbg_addr = 8'h30;
        #4;
        chk("seq dbg_gnt", 100, 32'(bus.dbg_gnt), 32'd1);
        @(posedge clk);
        #1;
        bus.dbg_req = 1'b0;
        lat = 1;
        #4;
        while (!bus.dbg_rvalid && lat < 5) begin
            @(posedge clk);
            #5;
            lat++;
        end
        chk("seq dbg_rvalid latency", 100, 32'(lat), 32'd1);
        chk("seq dbg_rdata", 100, bus.dbg_rdata, A3);
        @(posedge clk);
        #1;
        #4;
        chk("seq dbg_rvalid drop", 101, 32'(bus.dbg_rvalid), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
